// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one dual-mode adder (full-width or two half-width lanes)
// among N_REQ requesters, with a single registered, id-tagged result stage.
module adder_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_bit_mode,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]        res_id
);

    localparam int HALF = WIDTH / 2;

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // Ready may depend on valid, never the reverse; a producer holds valid and data
    // until it sees ready, and the result holds stable while res_ready is low.

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  grant_id;
    logic             grant_valid;
    logic             accept_en;
    logic             transfer;
    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];
    logic [WIDTH-1:0] sum;

    function automatic logic [WIDTH-1:0] dual_sum(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             lanes
    );
        logic [WIDTH-1:0] s;
        if (lanes) begin
            // Separate adds so no carry leaks from the low lane into the high lane.
            s[HALF-1:0]     = a[HALF-1:0] + b[HALF-1:0];
            s[WIDTH-1:HALF] = a[WIDTH-1:HALF] + b[WIDTH-1:HALF];
        end else begin
            s = a + b;
        end
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Scan from the farthest offset back to ptr so the nearest valid requester wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_valid[ID_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign accept_en = ~res_valid | res_ready;
    assign transfer  = grant_valid & accept_en & rst_n;
    assign sum       = dual_sum(a_arr[grant_id], b_arr[grant_id], req_bit_mode[grant_id]);
    assign ptr_next  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            ptr       <= '0;
        end else if (transfer) begin
            res_valid <= 1'b1;
            res_data  <= sum;
            res_id    <= grant_id;
            ptr       <= ptr_next;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed plus randomized bench for adder_arbiter, checked against a behavioural
// model of the arbitration and adder rules.
module tb_adder_arbiter;

    localparam int W    = 32;
    localparam int N    = 4;
    localparam int ID_W = $clog2(N);
    localparam int H    = W / 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_bit_mode;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [ID_W-1:0]  res_id;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    int           m_ptr;

    adder_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_bit_mode (req_bit_mode),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_id       (res_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic lanes);
        longint unsigned m_full, m_half, ua, ub, lo, hi;
        m_full = 64'd1 << W;
        m_half = 64'd1 << H;
        ua = 64'(a);
        ub = 64'(b);
        if (!lanes) return W'((ua + ub) % m_full);
        lo = ((ua % m_half) + (ub % m_half)) % m_half;
        hi = ((ua / m_half) + (ub / m_half)) % m_half;
        return W'(hi * m_half + lo);
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic mode);
        req_valid[i]         = v;
        req_a[i*W +: W]      = a;
        req_b[i*W +: W]      = b;
        req_bit_mode[i]      = mode;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W]  = $urandom;
            req_b[i*W +: W]  = $urandom;
            req_bit_mode[i]  = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: check combinational ready, step the model across the edge, check outputs.
    task automatic cycle();
        int           gid;
        logic [N-1:0] er;
        logic [W-1:0] s;
        #1;
        gid = model_grant();
        er  = '0;
        s   = '0;
        if (gid >= 0 && (!m_valid || res_ready)) begin
            er = N'(1 << gid);
            s  = ref_sum(req_a[gid*W +: W], req_b[gid*W +: W], req_bit_mode[gid]);
        end
        check("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        if (er != '0) begin
            m_valid = 1'b1;
            m_data  = s;
            m_id    = gid;
            m_ptr   = (gid + 1) % N;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("res_valid", 64'(res_valid), 64'(m_valid));
        check("res_data", 64'(res_data), 64'(m_data));
        check("res_id", 64'(res_id), 64'(m_id));
    endtask

    // Asserts reset between edges and checks the outputs clear immediately.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        req_bit_mode = '0;
        res_ready    = 1'b1;
        model_reset();
        #1;
        check("init_res_valid", 64'(res_valid), 64'd0);
        check("init_res_data", 64'(res_data), 64'd0);
        check("init_res_id", 64'(res_id), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Full-width carry through bit 16
        set_req(0, 1'b1, 32'h0001_FFFF, 32'h0000_0001, 1'b0);
        #1;
        check("carry_ready", 64'(req_ready), 64'h1);
        cycle();
        check("carry_data", 64'(res_data), 64'h0002_0000);
        check("carry_id", 64'(res_id), 64'd0);

        // Lane isolation
        set_req(0, 1'b1, 32'h0001_FFFF, 32'h0000_0001, 1'b1);
        cycle();
        check("lane_data0", 64'(res_data), 64'h0001_0000);
        set_req(0, 1'b1, 32'h7FFF_7FFF, 32'h0001_0001, 1'b1);
        cycle();
        check("lane_data1", 64'(res_data), 64'h8000_8000);

        // Round-robin streaming from ptr=0
        req_valid = '0;
        pulse_reset();
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            rand_operands();
            cycle();
            check("rr_id", 64'(res_id), 64'(k % N));
            check("rr_valid", 64'(res_valid), 64'd1);
        end

        // Pointer skip: only 1 and 3, then 2 joins while ptr=2
        req_valid = '0;
        pulse_reset();
        req_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            rand_operands();
            cycle();
            check("skip_id", 64'(res_id), (k % 2 == 0) ? 64'd1 : 64'd3);
        end
        req_valid = 4'b1110;
        cycle();
        check("skip_id2", 64'(res_id), 64'd2);
        cycle();
        check("skip_id3", 64'(res_id), 64'd3);

        // Backpressure with everyone requesting
        req_valid = '1;
        res_ready = 1'b1;
        rand_operands();
        cycle();
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_operands();
            cycle();
        end
        res_ready = 1'b1;
        cycle();
        check("bp_resume_id", 64'(res_id), 64'd1);

        // Async reset while a result is held, then restart from requester 0
        req_valid = 4'b1100;
        check("pre_rst_valid", 64'(res_valid), 64'd1);
        pulse_reset();
        cycle();
        check("post_rst_id", 64'(res_id), 64'd2);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            res_ready = ($urandom_range(0, 3) != 0);
            rand_operands();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
